vta_host_regfile: RTL and testbench

- Responder end of the host DPI request/response interface: consumes host register requests (read/write, address, value), acknowledges each with a one-cycle dequeue pulse, and returns read data.
- Holds the accelerator control/status register set: launch/finish control, an event cycle counter, scalar value registers and pointer registers.
- Sits between the host DPI requester and the accelerator core; its launch, vals and ptrs outputs drive the core, and its finish input comes from the core.

---
 rtl/vta_host_pkg.sv | 22 ++
 rtl/vta_host_regfile_if.sv | 29 ++
 rtl/vta_event_counter.sv | 22 ++
 rtl/vta_host_regfile.sv | 147 ++++++++++++++
 tb/tb_vta_host_regfile.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vta_host_pkg.sv
// Shared types and constants for the VTA host register file: opcodes, FSM states,
// register word indices and CTRL bit positions.
package vta_host_pkg;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DRAIN = 2'd3
    } host_state_e;

    localparam int IDX_CTRL = 0;
    localparam int IDX_ECNT = 1;
    localparam int IDX_VAL0 = 2;

    localparam int CTRL_LAUNCH_BIT = 0;
    localparam int CTRL_FINISH_BIT = 1;

endpackage

// File: rtl/vta_host_regfile_if.sv
// Host request/response bundle between the DPI requester (master) and the
// register file (slave).
interface vta_host_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32
);
    // Handshake: the master holds host_req_valid with stable opcode/addr/value until
    // it sees a one-cycle host_req_deq, and may drop valid one cycle after deq.
    // host_resp_valid is a one-cycle pulse carrying host_resp_bits; it has no ready,
    // so the master must always accept it. Only reads produce a response.
    logic                 host_req_valid;
    logic                 host_req_opcode;
    logic [ADDR_BITS-1:0] host_req_addr;
    logic [DATA_BITS-1:0] host_req_value;
    logic                 host_req_deq;
    logic                 host_resp_valid;
    logic [DATA_BITS-1:0] host_resp_bits;

    modport master (
        output host_req_valid, host_req_opcode, host_req_addr, host_req_value,
        input  host_req_deq, host_resp_valid, host_resp_bits
    );

    modport slave (
        input  host_req_valid, host_req_opcode, host_req_addr, host_req_value,
        output host_req_deq, host_resp_valid, host_resp_bits
    );

endinterface

// File: rtl/vta_event_counter.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module vta_event_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vta_host_regfile.sv
// Accelerator control/status register file answering host register requests:
// CTRL (launch/finish), saturating event counter, scalar values and pointers.
module vta_host_regfile
    import vta_host_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32,
    parameter int NUM_VALS  = 1,
    parameter int NUM_PTRS  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    vta_host_if.slave                     host,
    input  logic                          finish,
    output logic                          launch,
    output logic [NUM_VALS*DATA_BITS-1:0] vals,
    output logic [NUM_PTRS*DATA_BITS-1:0] ptrs,
    output host_state_e                   dbg_state
);

    localparam int IW = ADDR_BITS - 2;

    host_state_e          state;
    logic [IW-1:0]        req_idx;
    logic [IW-1:0]        wr_idx;
    logic [DATA_BITS-1:0] wr_value;
    logic                 deq_q;
    logic                 resp_valid_q;
    logic [DATA_BITS-1:0] resp_bits_q;
    logic [DATA_BITS-1:0] rd_data;
    logic                 ctrl_launch;
    logic                 ctrl_finish;
    logic [DATA_BITS-1:0] ecnt;
    logic                 ecnt_clr;
    logic                 do_write;
    logic [DATA_BITS-1:0] val_r [NUM_VALS];
    logic [DATA_BITS-1:0] ptr_r [NUM_PTRS];
    logic                 unused_addr_lsbs;

    assign req_idx          = host.host_req_addr[ADDR_BITS-1:2];
    assign unused_addr_lsbs = ^host.host_req_addr[1:0];
    assign do_write         = (state == ST_WRITE);

    // Read data is taken from the incoming address so it is sampled on the IDLE->READ edge.
    always_comb begin
        rd_data = '0;
        if (req_idx == IW'(IDX_CTRL)) begin
            rd_data[CTRL_LAUNCH_BIT] = ctrl_launch;
            rd_data[CTRL_FINISH_BIT] = ctrl_finish;
        end
        if (req_idx == IW'(IDX_ECNT)) begin
            rd_data = ecnt;
        end
        for (int i = 0; i < NUM_VALS; i++) begin
            if (req_idx == IW'(IDX_VAL0 + i)) rd_data = val_r[i];
        end
        for (int i = 0; i < NUM_PTRS; i++) begin
            if (req_idx == IW'(IDX_VAL0 + NUM_VALS + i)) rd_data = ptr_r[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            wr_idx       <= '0;
            wr_value     <= '0;
            deq_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_bits_q  <= '0;
        end else begin
            deq_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_bits_q  <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (host.host_req_valid) begin
                        wr_idx   <= req_idx;
                        wr_value <= host.host_req_value;
                        deq_q    <= 1'b1;
                        if (host.host_req_opcode == OP_WR) begin
                            state <= ST_WRITE;
                        end else begin
                            state        <= ST_READ;
                            resp_valid_q <= 1'b1;
                            resp_bits_q  <= rd_data;
                        end
                    end
                end
                ST_READ, ST_WRITE: state <= ST_DRAIN;
                ST_DRAIN:          state <= ST_IDLE;
                default:           state <= ST_IDLE;
            endcase
        end
    end

    // A launching CTRL write restarts the event count unless finish overrides it.
    assign ecnt_clr = do_write && (wr_idx == IW'(IDX_CTRL)) && wr_value[CTRL_LAUNCH_BIT]
                      && !ctrl_launch && !finish;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_launch <= 1'b0;
            ctrl_finish <= 1'b0;
            for (int i = 0; i < NUM_VALS; i++) val_r[i] <= '0;
            for (int i = 0; i < NUM_PTRS; i++) ptr_r[i] <= '0;
        end else begin
            if (do_write) begin
                if (wr_idx == IW'(IDX_CTRL)) begin
                    ctrl_launch <= wr_value[CTRL_LAUNCH_BIT];
                    ctrl_finish <= wr_value[CTRL_FINISH_BIT];
                end
                for (int i = 0; i < NUM_VALS; i++) begin
                    if (wr_idx == IW'(IDX_VAL0 + i)) val_r[i] <= wr_value;
                end
                for (int i = 0; i < NUM_PTRS; i++) begin
                    if (wr_idx == IW'(IDX_VAL0 + NUM_VALS + i)) ptr_r[i] <= wr_value;
                end
            end
            if (finish) begin
                ctrl_launch <= 1'b0;
                ctrl_finish <= 1'b1;
            end
        end
    end

    vta_event_counter #(.WIDTH(DATA_BITS)) u_ecnt (
        .clock (clock),
        .reset (reset),
        .en    (ctrl_launch),
        .clr   (ecnt_clr),
        .count (ecnt)
    );

    for (genvar g = 0; g < NUM_VALS; g++) begin : g_vals
        assign vals[g*DATA_BITS +: DATA_BITS] = val_r[g];
    end
    for (genvar g = 0; g < NUM_PTRS; g++) begin : g_ptrs
        assign ptrs[g*DATA_BITS +: DATA_BITS] = ptr_r[g];
    end

    assign launch               = ctrl_launch;
    assign host.host_req_deq    = deq_q;
    assign host.host_resp_valid = resp_valid_q;
    assign host.host_resp_bits  = resp_bits_q;
    assign dbg_state            = state;

endmodule

// File: tb/tb_vta_host_regfile.sv
// Scoreboarded bench for vta_host_regfile: requests are driven against a register-map
// model, read expectations are queued and a negedge monitor checks every response.
module tb_vta_host_regfile;
    import vta_host_pkg::*;

    localparam int AB   = 8;
    localparam int DB   = 32;
    localparam int NV   = 1;
    localparam int NP   = 4;
    localparam int NMAP = IDX_VAL0 + NV + NP;

    // ---------------- clock / reset ----------------
    logic             clock  = 1'b0;
    logic             reset  = 1'b1;
    logic             finish = 1'b0;
    logic             launch;
    logic [NV*DB-1:0] vals;
    logic [NP*DB-1:0] ptrs;
    host_state_e      dbg_state;
    int               cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    vta_host_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) host ();

    vta_host_regfile #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_VALS(NV), .NUM_PTRS(NP)) dut (
        .clock     (clock),
        .reset     (reset),
        .host      (host),
        .finish    (finish),
        .launch    (launch),
        .vals      (vals),
        .ptrs      (ptrs),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    logic [DB-1:0] m_ctrl, m_ecnt, m_ecnt_tol;
    logic [DB-1:0] m_vals [NV];
    logic [DB-1:0] m_ptrs [NP];

    function automatic void model_reset();
        m_ctrl = '0; m_ecnt = '0; m_ecnt_tol = '0;
        for (int i = 0; i < NV; i++) m_vals[i] = '0;
        for (int i = 0; i < NP; i++) m_ptrs[i] = '0;
    endfunction

    function automatic logic [DB-1:0] model_read(input int idx);
        if (idx == IDX_CTRL) return m_ctrl;
        if (idx == IDX_ECNT) return m_ecnt;
        if (idx >= IDX_VAL0 && idx < IDX_VAL0 + NV) return m_vals[idx - IDX_VAL0];
        if (idx >= IDX_VAL0 + NV && idx < NMAP) return m_ptrs[idx - IDX_VAL0 - NV];
        return '0;
    endfunction

    function automatic void model_write(input int idx, input logic [DB-1:0] v);
        if (idx == IDX_CTRL) begin
            if (v[0] && !m_ctrl[0]) begin m_ecnt = '0; m_ecnt_tol = '0; end
            m_ctrl = {30'd0, v[1:0]};
        end else if (idx >= IDX_VAL0 && idx < IDX_VAL0 + NV) begin
            m_vals[idx - IDX_VAL0] = v;
        end else if (idx >= IDX_VAL0 + NV && idx < NMAP) begin
            m_ptrs[idx - IDX_VAL0 - NV] = v;
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [DB-1:0] exp_q [$];
    logic [DB-1:0] tol_q [$];
    int checks = 0, errors = 0, deq_cnt = 0, resp_cnt = 0;

    task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (host.host_req_deq) deq_cnt++;
            if (host.host_resp_valid) begin
                logic [DB-1:0] e, t, act, diff;
                resp_cnt++;
                checks++;
                if (!host.host_req_deq) begin
                    errors++;
                    $display("FAIL resp_without_deq: deq=%b expected 1", host.host_req_deq);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got %h expected no response", host.host_resp_bits);
                end else begin
                    e    = exp_q.pop_front();
                    t    = tol_q.pop_front();
                    act  = host.host_resp_bits;
                    diff = (act >= e) ? act - e : e - act;
                    if (diff > t) begin
                        errors++;
                        $display("FAIL resp_data: got %h expected %h (tol %0d)", act, e, t);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (dbg_state != ST_IDLE && n < 10) begin @(negedge clock); n++; end
    endtask

    // Issues one request and returns at the negedge of the cycle carrying deq.
    task automatic do_req(input logic op, input logic [AB-1:0] addr, input logic [DB-1:0] value,
                          input bit fin_on_deq, output int deq_cyc);
        int n = 0;
        int idx = int'(addr[AB-1:2]);
        if (op == OP_RD) begin
            exp_q.push_back(model_read(idx));
            tol_q.push_back(idx == IDX_ECNT ? m_ecnt_tol : '0);
        end
        @(negedge clock);
        host.host_req_valid  = 1'b1;
        host.host_req_opcode = op;
        host.host_req_addr   = addr;
        host.host_req_value  = value;
        do begin @(negedge clock); n++; end while (!host.host_req_deq && n < 20);
        checks++;
        if (!host.host_req_deq) begin
            errors++;
            $display("FAIL deq_timeout: got no deq within %0d cycles, expected deq", n);
        end
        deq_cyc = cyc;
        if (fin_on_deq) finish = 1'b1;
        host.host_req_valid = 1'b0;
        if (op == OP_WR) model_write(idx, value);
    endtask

    task automatic rd(input logic [AB-1:0] addr);
        int dc;
        do_req(OP_RD, addr, $urandom, 1'b0, dc);
    endtask

    task automatic wr(input logic [AB-1:0] addr, input logic [DB-1:0] value);
        int dc;
        do_req(OP_WR, addr, value, 1'b0, dc);
    endtask

    task automatic read_all();
        for (int i = 0; i < NMAP; i++) rd(AB'(i * 4 + $urandom_range(0, 3)));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wc, fc, d0, r0, dc;
        host.host_req_valid  = 1'b0;
        host.host_req_opcode = 1'b0;
        host.host_req_addr   = '0;
        host.host_req_value  = '0;
        model_reset();

        repeat (3) @(negedge clock);
        check("reset_launch", DB'(launch), '0);
        check("reset_deq", DB'(host.host_req_deq), '0);
        check("reset_state", DB'(dbg_state), DB'(ST_IDLE));
        reset = 1'b0;
        rd(8'h00);

        // value register write/read and output timing
        wr(8'h08, 32'hDEADBEEF);
        check("vals_before_update", vals[31:0], '0);
        @(negedge clock);
        check("vals_after_write", vals[31:0], 32'hDEADBEEF);
        rd(8'h08);

        // launch, count, finish
        do_req(OP_WR, 8'h00, 32'h1, 1'b0, wc);
        repeat (10) @(negedge clock);
        check("launch_running", DB'(launch), 1);
        repeat (89) @(negedge clock);
        finish = 1'b1;
        fc = cyc;
        @(negedge clock);
        finish = 1'b0;
        m_ctrl = 32'h2;
        m_ecnt = DB'(fc - wc);
        m_ecnt_tol = 1;
        check("launch_after_finish", DB'(launch), 0);
        rd(8'h04);
        rd(8'h00);
        repeat (20) @(negedge clock);
        rd(8'h05);

        // unmapped access
        rd(8'hFC);
        wr(8'hFC, $urandom);
        read_all();

        // randomized traffic; launching CTRL writes are excluded to keep ECNT frozen
        for (int k = 0; k < 40; k++) begin
            logic [AB-1:0] a = AB'($urandom_range(0, 255));
            logic [DB-1:0] v = $urandom;
            if (a[AB-1:2] == 0) v[0] = 1'b0;
            if ($urandom_range(0, 1) == 1) wr(a, v);
            else rd(a);
        end
        read_all();

        // valid held high: one capture per three cycles
        wait_idle();
        d0 = deq_cnt;
        r0 = resp_cnt;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(m_vals[0]);
            tol_q.push_back('0);
        end
        host.host_req_valid  = 1'b1;
        host.host_req_opcode = OP_RD;
        host.host_req_addr   = 8'h08;
        repeat (12) @(negedge clock);
        host.host_req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("b2b_deq_count", DB'(deq_cnt - d0), 4);
        check("b2b_resp_count", DB'(resp_cnt - r0), 4);

        // finish collides with a launching CTRL write
        wait_idle();
        do_req(OP_WR, 8'h00, 32'h1, 1'b1, dc);
        @(negedge clock);
        finish = 1'b0;
        m_ctrl = 32'h2;
        check("collision_launch", DB'(launch), 0);
        rd(8'h00);

        // reset while a read is in flight
        wr(8'h0C, 32'h1234_5678);
        wr(8'h08, 32'hA5A5_0001);
        wait_idle();
        host.host_req_valid  = 1'b1;
        host.host_req_opcode = OP_RD;
        host.host_req_addr   = 8'h0C;
        @(posedge clock);
        #2;
        check("midop_in_read", DB'(dbg_state), DB'(ST_READ));
        reset = 1'b1;
        host.host_req_valid = 1'b0;
        #1;
        check("midop_resp_dropped", DB'(host.host_resp_valid), 0);
        check("midop_deq_dropped", DB'(host.host_req_deq), 0);
        check("midop_state", DB'(dbg_state), DB'(ST_IDLE));
        check("midop_vals", vals[31:0], '0);
        check("midop_ptr0", ptrs[31:0], '0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        read_all();

        repeat (5) @(negedge clock);
        check("scoreboard_drained", DB'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
